rtype_exec_sequencer: RTL and testbench

RTYPE_EXEC_SEQUENCER -- requirements
Module: rtype_exec_sequencer

---
 rtl/rtype_exec_sequencer.sv | 156 +++++++++++++++
 tb/tb_rtype_exec_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_exec_sequencer.sv
// RV32I integer register-register / register-immediate execution sequencer.
// Takes one instruction per 4 cycles through IDLE -> READ -> EXEC -> WRITE,
// or IDLE -> ERROR for encodings outside the supported ALU subset.
module rtype_exec_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  rd_addr0,
  output logic [4:0]  rd_addr1,
  input  logic [31:0] rd_data0,
  input  logic [31:0] rd_data1,
  output logic        wr_ena,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        instr_legal;

  // Latched instruction fields (only what EXEC/WRITE actually need)
  logic        is_r_q;
  logic [2:0]  f3_q;
  logic [11:0] imm_q;
  logic [4:0]  rd_q;

  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [31:0] result;

  logic [31:0] opb;
  logic [4:0]  shamt;
  logic [31:0] alu;

  // Status outputs decoded from state and registered write address
  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == WRITE);
  assign illegal     = (state == ERROR);
  assign wr_ena      = (state == WRITE) && (wr_addr != 5'd0);
  assign wr_data     = result;

  // Legality of the instruction currently offered on the instr input
  always_comb begin
    instr_legal = 1'b0;
    case (instr[6:0])
      OP_R: begin
        if (instr[31:25] == F7_BASE)
          instr_legal = 1'b1;
        else if (instr[31:25] == F7_ALT)
          instr_legal = (instr[14:12] == 3'b000) || (instr[14:12] == 3'b101);
        else
          instr_legal = 1'b0;
      end
      OP_I: begin
        case (instr[14:12])
          3'b001:  instr_legal = (instr[31:25] == F7_BASE);
          3'b101:  instr_legal = (instr[31:25] == F7_BASE) || (instr[31:25] == F7_ALT);
          default: instr_legal = 1'b1;
        endcase
      end
      default: instr_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (instr_valid) next_state = instr_legal ? READ : ERROR;
      READ:    next_state = EXEC;
      EXEC:    next_state = WRITE;
      WRITE:   next_state = IDLE;
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ALU on latched operands; I-type uses the sign-extended immediate
  always_comb begin
    opb   = is_r_q ? op2_q : {{20{imm_q[11]}}, imm_q};
    shamt = opb[4:0];
    alu   = 32'd0;
    case (f3_q)
      3'b000:  alu = (is_r_q && imm_q[10]) ? (op1_q - opb) : (op1_q + opb);
      3'b001:  alu = op1_q << shamt;
      3'b010:  alu = {31'd0, ($signed(op1_q) < $signed(opb))};
      3'b011:  alu = {31'd0, (op1_q < opb)};
      3'b100:  alu = op1_q ^ opb;
      3'b101:  alu = imm_q[10] ? 32'($signed(op1_q) >>> shamt) : (op1_q >> shamt);
      3'b110:  alu = op1_q | opb;
      default: alu = op1_q & opb;
    endcase
  end

  // Datapath registers: fields on accept, operands in READ, result in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      is_r_q   <= 1'b0;
      f3_q     <= 3'd0;
      imm_q    <= 12'd0;
      rd_q     <= 5'd0;
      rd_addr0 <= 5'd0;
      rd_addr1 <= 5'd0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      result   <= 32'd0;
      wr_addr  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid && instr_legal) begin
            is_r_q   <= instr[5];
            f3_q     <= instr[14:12];
            imm_q    <= instr[31:20];
            rd_q     <= instr[11:7];
            rd_addr0 <= instr[19:15];
            rd_addr1 <= instr[24:20];
          end
        end
        READ: begin
          op1_q <= rd_data0;
          op2_q <= rd_data1;
        end
        EXEC: begin
          result  <= alu;
          wr_addr <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// Self-checking bench for rtype_exec_sequencer: directed vector table,
// multi-cycle corner sequences, and randomized instructions vs. a reference model.
module tb_rtype_exec_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        illegal;

  logic [31:0] rf [32];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        legal;
    logic [31:0] data;
  } vec_t;

  localparam int unsigned NVEC = 19;
  vec_t vecs [NVEC];

  rtype_exec_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rd_addr0    (rd_addr0),
    .rd_addr1    (rd_addr1),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .wr_ena      (wr_ena),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  assign rd_data0 = rf[rd_addr0];
  assign rd_data1 = rf[rd_addr1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Reference: ISA semantics by mnemonic
  function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                    input logic [31:0] b, output logic legal,
                                    output logic [31:0] res);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] immv;
    logic [4:0]  sh;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    immv = {{20{ins[31]}}, ins[31:20]};
    legal = 1'b1;
    res   = 32'd0;
    if (opc == 7'b0110011) begin
      sh = b[4:0];
      case ({f7, f3})
        {7'h00, 3'd0}: res = a + b;
        {7'h20, 3'd0}: res = a - b;
        {7'h00, 3'd1}: res = a << sh;
        {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        {7'h00, 3'd3}: res = (a < b) ? 32'd1 : 32'd0;
        {7'h00, 3'd4}: res = a ^ b;
        {7'h00, 3'd5}: res = a >> sh;
        {7'h20, 3'd5}: res = $unsigned($signed(a) >>> sh);
        {7'h00, 3'd6}: res = a | b;
        {7'h00, 3'd7}: res = a & b;
        default:       legal = 1'b0;
      endcase
    end else if (opc == 7'b0010011) begin
      sh = ins[24:20];
      case (f3)
        3'd0: res = a + immv;
        3'd2: res = ($signed(a) < $signed(immv)) ? 32'd1 : 32'd0;
        3'd3: res = (a < immv) ? 32'd1 : 32'd0;
        3'd4: res = a ^ immv;
        3'd6: res = a | immv;
        3'd7: res = a & immv;
        3'd1: begin
          legal = (f7 == 7'h00);
          res = a << sh;
        end
        default: begin
          if (f7 == 7'h00)      res = a >> sh;
          else if (f7 == 7'h20) res = $unsigned($signed(a) >>> sh);
          else                  legal = 1'b0;
        end
      endcase
    end else begin
      legal = 1'b0;
    end
  endfunction

  task automatic load_rf(input logic [31:0] ins, input logic [31:0] v1, input logic [31:0] v2);
    rf[ins[24:20]] = v2;
    rf[ins[19:15]] = v1;
    rf[0] = 32'd0;
  endtask

  // Issue one instruction from IDLE and check every cycle until back in IDLE.
  // instr_valid stays high with junk while busy; it must be ignored.
  task automatic run_instr(input logic [31:0] ins, input logic exp_legal, input logic [31:0] exp_data);
    logic [4:0] rd;
    rd = ins[11:7];
    @(negedge clk);
    chk("ready_in_idle", 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 32'h0000_0033;
    if (exp_legal) begin
      chk("read_busy", 32'(busy), 32'd1);
      chk("read_ready", 32'(instr_ready), 32'd0);
      chk("read_illegal", 32'(illegal), 32'd0);
      chk("read_rd_addr0", 32'(rd_addr0), 32'(ins[19:15]));
      chk("read_rd_addr1", 32'(rd_addr1), 32'(ins[24:20]));
      chk("read_wr_ena", 32'(wr_ena), 32'd0);
      @(posedge clk); #1;
      chk("exec_wr_ena", 32'(wr_ena), 32'd0);
      chk("exec_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("write_done", 32'(done), 32'd1);
      chk("write_wr_ena", 32'(wr_ena), 32'(rd != 5'd0));
      chk("write_wr_addr", 32'(wr_addr), 32'(rd));
      chk("write_wr_data", wr_data, exp_data);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("post_done", 32'(done), 32'd0);
      chk("post_wr_ena", 32'(wr_ena), 32'd0);
      chk("post_ready", 32'(instr_ready), 32'd1);
      chk("post_wr_data_hold", wr_data, exp_data);
      chk("post_wr_addr_hold", 32'(wr_addr), 32'(rd));
    end else begin
      chk("err_illegal", 32'(illegal), 32'd1);
      chk("err_wr_ena", 32'(wr_ena), 32'd0);
      chk("err_done", 32'(done), 32'd0);
      chk("err_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("err_after_illegal", 32'(illegal), 32'd0);
      chk("err_after_ready", 32'(instr_ready), 32'd1);
      chk("err_after_wr_ena", 32'(wr_ena), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_legal;
    logic [31:0] exp_data;
    int          sel;
    logic [6:0]  opc;
    logic [6:0]  f7;

    for (int i = 0; i < 32; i++) rf[i] = 32'd0;

    vecs[0]  = '{r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 1'b1, 32'd12};
    vecs[1]  = '{r_ins(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF};
    vecs[2]  = '{i_ins(12'h404, 5'd6, 3'd5, 5'd5), 32'h8000_0000, 32'd0, 1'b1, 32'hF800_0000};
    vecs[3]  = '{i_ins(12'hFFF, 5'd0, 3'd3, 5'd7), 32'd0, 32'd9, 1'b1, 32'd1};
    vecs[4]  = '{i_ins(12'h001, 5'd1, 3'd0, 5'd0), 32'd5, 32'd0, 1'b1, 32'd6};
    vecs[5]  = '{32'h0000_007F, 32'd0, 32'd0, 1'b0, 32'd0};
    vecs[6]  = '{i_ins(12'h403, 5'd1, 3'd1, 5'd2), 32'd1, 32'd0, 1'b0, 32'd0};
    vecs[7]  = '{r_ins(7'h00, 5'd10, 5'd9, 3'd2, 5'd8), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1};
    vecs[8]  = '{r_ins(7'h00, 5'd10, 5'd9, 3'd3, 5'd8), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0};
    vecs[9]  = '{r_ins(7'h20, 5'd13, 5'd12, 3'd5, 5'd11), 32'hF000_0000, 32'h24, 1'b1, 32'hFF00_0000};
    vecs[10] = '{r_ins(7'h00, 5'd13, 5'd12, 3'd5, 5'd11), 32'hF000_0000, 32'd4, 1'b1, 32'h0F00_0000};
    vecs[11] = '{r_ins(7'h00, 5'd13, 5'd12, 3'd1, 5'd11), 32'd1, 32'd31, 1'b1, 32'h8000_0000};
    vecs[12] = '{i_ins(12'h800, 5'd14, 3'd4, 5'd20), 32'h0000_FFFF, 32'd0, 1'b1, 32'hFFFF_07FF};
    vecs[13] = '{r_ins(7'h20, 5'd2, 5'd1, 3'd7, 5'd3), 32'd3, 32'd3, 1'b0, 32'd0};
    vecs[14] = '{r_ins(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'd3, 32'd3, 1'b0, 32'd0};
    vecs[15] = '{i_ins(12'h0F0, 5'd14, 3'd7, 5'd21), 32'h1234_5678, 32'd0, 1'b1, 32'h0000_0070};
    vecs[16] = '{i_ins(12'h01F, 5'd15, 3'd5, 5'd22), 32'h8000_0000, 32'd0, 1'b1, 32'd1};
    vecs[17] = '{r_ins(7'h00, 5'd2, 5'd1, 3'd0, 5'd23), 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1};
    vecs[18] = '{r_ins(7'h00, 5'd2, 5'd1, 3'd6, 5'd24), 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 32'hF0F0_0F0F};

    rst = 1'b1;
    instr = 32'd0;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_wr_ena", 32'(wr_ena), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_rd_addr0", 32'(rd_addr0), 32'd0);
    chk("rst_rd_addr1", 32'(rd_addr1), 32'd0);
    rst = 1'b0;

    // Directed table
    for (int v = 0; v < int'(NVEC); v++) begin
      load_rf(vecs[v].ins, vecs[v].v1, vecs[v].v2);
      run_instr(vecs[v].ins, vecs[v].legal, vecs[v].data);
    end

    // Reset asserted during EXEC aborts the instruction
    load_rf(vecs[0].ins, 32'd5, 32'd7);
    @(negedge clk);
    instr = vecs[0].ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_exec_wr_ena", 32'(wr_ena), 32'd0);
    chk("rst_exec_done", 32'(done), 32'd0);
    chk("rst_exec_ready", 32'(instr_ready), 32'd1);
    chk("rst_exec_wr_data", wr_data, 32'd0);
    chk("rst_exec_rd_addr0", 32'(rd_addr0), 32'd0);
    @(posedge clk); #1;
    chk("rst_exec_after_wr_ena", 32'(wr_ena), 32'd0);
    chk("rst_exec_after_done", 32'(done), 32'd0);

    // Reset overrides an accept in the same cycle
    @(negedge clk);
    instr = vecs[0].ins;
    instr_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    instr_valid = 1'b0;
    chk("rst_accept_busy", 32'(busy), 32'd0);
    chk("rst_accept_rd_addr0", 32'(rd_addr0), 32'd0);
    @(posedge clk); #1;
    chk("rst_accept_no_done", 32'(done), 32'd0);

    // Back-to-back: valid held high accepts exactly every 4 cycles
    load_rf(vecs[0].ins, 32'd5, 32'd7);
    @(negedge clk);
    instr = vecs[0].ins;
    instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("b2b_ready", 32'(instr_ready), 32'((c % 4) == 0));
      chk("b2b_done", 32'(done), 32'((c % 4) == 3));
      chk("b2b_wr_ena", 32'(wr_ena), 32'((c % 4) == 3));
      if ((c % 4) == 3) chk("b2b_wr_data", wr_data, 32'd12);
      @(posedge clk);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Randomized instructions against the reference model
    for (int n = 0; n < 250; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      opc = 7'b0110011;
      else if (sel < 8) opc = 7'b0010011;
      else              opc = 7'($urandom());
      sel = int'($urandom_range(0, 3));
      if (sel < 2)       f7 = 7'h00;
      else if (sel == 2) f7 = 7'h20;
      else               f7 = 7'($urandom());
      ins = {f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()), opc};
      load_rf(ins, $urandom(), $urandom());
      a = rf[ins[19:15]];
      b = rf[ins[24:20]];
      ref_model(ins, a, b, exp_legal, exp_data);
      run_instr(ins, exp_legal, exp_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
